// File: rtl/uf_r_pkg.sv
// uf_r_pkg: shared opcode, state and sentinel definitions for the R-type station, issue logic and execution unit
package uf_r_pkg;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;
    localparam int CNT_W = 4;
    localparam logic [15:0] SEM_VALOR = 16'hFFF0;
    localparam logic [2:0] TAG_NONE = 3'd0;
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_OPS, S_EXEC, S_BCAST, S_FIN, S_RELEASE
    } state_t;
endpackage

// File: rtl/uf_r_alu.sv
// uf_r_alu: combinational R-type ALU
//   Ufop   opcode
//   a, b   operands
//   result a <op> b, wrapping; SLT is signed and yields 0/1; MUL keeps the low bits
module uf_r_alu
    import uf_r_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        Ufop,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);
    always_comb begin
        case (Ufop)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_MUL:  result = a * b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/uf_r_exec.sv
// uf_r_exec: R-type execution unit answering a reservation station
//   Clock, Reset                    clock, synchronous active-high reset
//   Busy, Ufop, Vj, Vk, Qj, Qk      station state sampled at launch
//   Clear_counter                   abort / hold-idle request
//   Cdb_valid, Cdb_tag, Cdb_data    CDB snoop for pending operand tags
//   Cdb_grant                       arbiter grant for our broadcast
//   Cdb_req, Cdb_req_tag/_data      broadcast request with RS_TAG and result
//   Done, Finished, Result          write-back enable, retire pulse, held result
module uf_r_exec
    import uf_r_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W = 3,
    parameter logic [TAG_W-1:0] RS_TAG = TAG_W'(1),
    parameter int LAT_MUL = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Busy,
    input  logic [2:0]        Ufop,
    input  logic [DATA_W-1:0] Vj,
    input  logic [DATA_W-1:0] Vk,
    input  logic [TAG_W-1:0]  Qj,
    input  logic [TAG_W-1:0]  Qk,
    input  logic              Clear_counter,
    input  logic              Cdb_valid,
    input  logic [TAG_W-1:0]  Cdb_tag,
    input  logic [DATA_W-1:0] Cdb_data,
    input  logic              Cdb_grant,
    output logic              Cdb_req,
    output logic [TAG_W-1:0]  Cdb_req_tag,
    output logic [DATA_W-1:0] Cdb_req_data,
    output logic              Done,
    output logic              Finished,
    output logic [DATA_W-1:0] Result
);
    state_t state, state_n;
    logic [2:0]        op;
    logic [DATA_W-1:0] vj, vk, res, alu_y;
    logic [TAG_W-1:0]  qj, qk;
    logic [CNT_W-1:0]  cnt;
    logic launch, ready, hit_j_in, hit_k_in, hit_j, hit_k;

    // Tag 0 means the value is already valid, so it never matches the CDB.
    assign hit_j_in = Cdb_valid && Qj != '0 && Cdb_tag == Qj;
    assign hit_k_in = Cdb_valid && Qk != '0 && Cdb_tag == Qk;
    assign hit_j    = Cdb_valid && qj != '0 && Cdb_tag == qj;
    assign hit_k    = Cdb_valid && qk != '0 && Cdb_tag == qk;
    assign launch   = state == S_IDLE && Busy && !Clear_counter;
    assign ready    = qj == '0 && qk == '0;

    uf_r_alu #(.DATA_W(DATA_W)) u_alu (.Ufop(op), .a(vj), .b(vk), .result(alu_y));

    always_ff @(posedge Clock) state <= Reset ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (launch) state_n = S_WAIT_OPS;
            S_WAIT_OPS: if (ready) state_n = op == OP_NOP ? S_FIN : S_EXEC;
            S_EXEC:     if (cnt == '0) state_n = S_BCAST;
            S_BCAST:    if (Cdb_grant) state_n = S_FIN;
            S_FIN:      state_n = Busy ? S_RELEASE : S_IDLE;
            S_RELEASE:  if (!Busy) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
        if (Clear_counter && state != S_IDLE) state_n = S_IDLE;
    end

    always_comb begin
        Done         = state == S_BCAST;
        Cdb_req      = state == S_BCAST;
        Cdb_req_tag  = Cdb_req ? RS_TAG : '0;
        Cdb_req_data = Cdb_req ? res : '0;
        Finished     = state == S_FIN;
    end

    assign Result = res;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            op  <= OP_NOP;
            vj  <= DATA_W'(SEM_VALOR);
            vk  <= DATA_W'(SEM_VALOR);
            qj  <= '0;
            qk  <= '0;
            cnt <= '0;
            res <= DATA_W'(SEM_VALOR);
        end else begin
            if (launch) begin
                op <= Ufop;
                vj <= hit_j_in ? Cdb_data : Vj;
                vk <= hit_k_in ? Cdb_data : Vk;
                qj <= hit_j_in ? '0 : Qj;
                qk <= hit_k_in ? '0 : Qk;
            end
            if (state == S_WAIT_OPS) begin
                if (hit_j) begin
                    vj <= Cdb_data;
                    qj <= '0;
                end
                if (hit_k) begin
                    vk <= Cdb_data;
                    qk <= '0;
                end
                // Counter holds remaining EXEC cycles minus one.
                cnt <= op == OP_MUL ? CNT_W'(LAT_MUL - 1) : '0;
            end
            if (state == S_EXEC) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0 && !Clear_counter) res <= alu_y;
            end
        end
    end
endmodule

// File: tb/tb_uf_r_exec.sv
// tb_uf_r_exec: directed self-checking bench for uf_r_exec
module tb_uf_r_exec;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Busy = 1'b0;
    logic [2:0]  Ufop = '0;
    logic [15:0] Vj = '0, Vk = '0;
    logic [2:0]  Qj = '0, Qk = '0;
    logic        Clear_counter = 1'b0;
    logic        Cdb_valid = 1'b0;
    logic [2:0]  Cdb_tag = '0;
    logic [15:0] Cdb_data = '0;
    logic        Cdb_grant = 1'b0;
    logic        Cdb_req, Done, Finished;
    logic [2:0]  Cdb_req_tag;
    logic [15:0] Cdb_req_data, Result;
    int n_cmp = 0;
    int n_err = 0;

    uf_r_exec #(.DATA_W(16), .TAG_W(3), .RS_TAG(3'd1), .LAT_MUL(3)) dut (
        .Clock(Clock), .Reset(Reset), .Busy(Busy), .Ufop(Ufop), .Vj(Vj), .Vk(Vk),
        .Qj(Qj), .Qk(Qk), .Clear_counter(Clear_counter), .Cdb_valid(Cdb_valid),
        .Cdb_tag(Cdb_tag), .Cdb_data(Cdb_data), .Cdb_grant(Cdb_grant),
        .Cdb_req(Cdb_req), .Cdb_req_tag(Cdb_req_tag), .Cdb_req_data(Cdb_req_data),
        .Done(Done), .Finished(Finished), .Result(Result)
    );

    always #5 Clock = ~Clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bcast(input string tag, input logic [15:0] data);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_req"}, 32'(Cdb_req), 32'd1);
        chk({tag, "_tag"}, 32'(Cdb_req_tag), 32'd1);
        chk({tag, "_data"}, 32'(Cdb_req_data), 32'(data));
        chk({tag, "_fin"}, 32'(Finished), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_req"}, 32'(Cdb_req), 32'd0);
        chk({tag, "_fin"}, 32'(Finished), 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] ta, input logic [2:0] tb);
        Busy = 1'b1; Ufop = op; Vj = a; Vk = b; Qj = ta; Qk = tb;
    endtask

    initial begin
        tick(2);
        chk_quiet("rst");
        chk("rst_tag", 32'(Cdb_req_tag), 32'd0);
        chk("rst_data", 32'(Cdb_req_data), 32'd0);
        chk("rst_result", 32'(Result), 32'hFFF0);
        Reset = 1'b0;
        tick();
        // ADD 5+7, ready operands, grant already high
        issue(3'b001, 16'd5, 16'd7, 3'd0, 3'd0);
        Cdb_grant = 1'b1;
        tick();
        chk_quiet("add_t1");
        tick();
        chk_quiet("add_t2");
        tick();
        chk_bcast("add_t3", 16'd12);
        Busy = 1'b0;
        tick();
        chk("add_fin", 32'(Finished), 32'd1);
        chk("add_fin_done", 32'(Done), 32'd0);
        chk("add_fin_req", 32'(Cdb_req), 32'd0);
        chk("add_result", 32'(Result), 32'd12);
        tick();
        chk_quiet("add_idle");
        // SUB 3-5 waiting on tag 2; Busy held to exercise RELEASE
        issue(3'b010, 16'd3, 16'd99, 3'd0, 3'd2);
        tick(2);
        chk_quiet("sub_wait");
        Cdb_valid = 1'b1; Cdb_tag = 3'd2; Cdb_data = 16'd5;
        tick();
        Cdb_valid = 1'b0;
        chk_quiet("sub_capture");
        tick();
        chk_quiet("sub_exec");
        tick();
        chk_bcast("sub", 16'hFFFE);
        tick();
        chk("sub_fin", 32'(Finished), 32'd1);
        tick();
        chk_quiet("rel_1");
        tick(3);
        chk_quiet("rel_4");
        Busy = 1'b0;
        tick();
        chk_quiet("rel_idle");
        // MUL 300*300 with three EXEC cycles
        issue(3'b111, 16'd300, 16'd300, 3'd0, 3'd0);
        tick();
        tick(3);
        chk_quiet("mul_exec3");
        tick();
        chk_bcast("mul", 16'h5F90);
        Busy = 1'b0;
        tick();
        chk("mul_fin", 32'(Finished), 32'd1);
        tick();
        // XOR with both tags 4 satisfied by one broadcast; grant withheld
        Cdb_grant = 1'b0;
        issue(3'b101, 16'd1, 16'd2, 3'd4, 3'd4);
        tick();
        Cdb_valid = 1'b1; Cdb_tag = 3'd4; Cdb_data = 16'd9;
        tick();
        Cdb_valid = 1'b0;
        tick(2);
        chk_bcast("xor", 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_bcast("hold", 16'd0);
        end
        Cdb_grant = 1'b1; Busy = 1'b0;
        tick();
        chk("xor_fin", 32'(Finished), 32'd1);
        chk("xor_fin_done", 32'(Done), 32'd0);
        tick();
        chk("xor_idle_fin", 32'(Finished), 32'd0);
        // Clear_counter mid-EXEC aborts, then holds idle despite Busy
        issue(3'b111, 16'd2, 16'd3, 3'd0, 3'd0);
        tick(2);
        Clear_counter = 1'b1;
        tick();
        chk_quiet("clr_1");
        tick(4);
        chk_quiet("clr_5");
        chk("clr_result", 32'(Result), 32'd0);
        Clear_counter = 1'b0; Busy = 1'b0;
        tick();
        // NOP skips EXEC and BCAST
        issue(3'b000, 16'd1, 16'd1, 3'd0, 3'd0);
        tick(2);
        chk("nop_fin", 32'(Finished), 32'd1);
        chk("nop_done", 32'(Done), 32'd0);
        Busy = 1'b0;
        tick();
        // SLT signed: -3 < 2
        issue(3'b110, 16'hFFFD, 16'd2, 3'd0, 3'd0);
        tick(3);
        chk_bcast("slt", 16'd1);
        Busy = 1'b0;
        tick(2);
        // AND with Qj forwarded from the CDB in the launch cycle, then reset in BCAST
        Cdb_grant = 1'b0;
        issue(3'b011, 16'hFFFF, 16'h00F0, 3'd3, 3'd0);
        Cdb_valid = 1'b1; Cdb_tag = 3'd3; Cdb_data = 16'h0F3C;
        tick();
        Cdb_valid = 1'b0;
        tick(2);
        chk_bcast("fwd", 16'h0030);
        Reset = 1'b1;
        tick();
        chk_quiet("rst2");
        chk("rst2_tag", 32'(Cdb_req_tag), 32'd0);
        chk("rst2_data", 32'(Cdb_req_data), 32'd0);
        chk("rst2_result", 32'(Result), 32'hFFF0);
        Reset = 1'b0; Busy = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
